pic_bus_responder: RTL and testbench

- CPU-facing output side of the 8259 PIC bus interface. It drives the bidirectional data bus toward the CPU, the opposite direction from the ICW/OCW write path.
- Serves status reads (IRR/ISR/IMR) on RD cycles.
- Sequences INTA cycles: 8086 mode uses 2 pulses; 8080/85 mode uses 3 pulses (CALL plus address).
- Emits single-cycle control pulses to the in-service/priority logic. Single (non-cascade) mode only.

---
 rtl/pic_bus_responder_if.sv | 12 +
 rtl/pic_bus_responder.sv | 210 +++++++++++++++++++++
 tb/tb_pic_bus_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_bus_responder_if.sv
// CPU-side bus of the 8259 responder: read/acknowledge strobes in, data byte and drive enable out.
interface pic_bus_responder_if;
  logic       rd;
  logic       CS;
  logic       A0;
  logic       inta;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output rd, CS, A0, inta, input d_out, d_oe);
  modport slave  (input rd, CS, A0, inta, output d_out, d_oe);
endinterface

// File: rtl/pic_bus_responder.sv
// 8259 bus responder: status reads and INTA byte sequencing toward the CPU, single mode only.
// Optional macro POLL_CMD_EN adds the OCW3 poll read (extra input poll).
module pic_bus_responder #(
  parameter logic [7:0] CALL_OPCODE    = 8'hCD,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pic_bus_responder_if.slave    bus,
  input  logic [7:0]            irr,
  input  logic [7:0]            isr,
  input  logic [7:0]            imr,
  input  logic                  ris,
  input  logic                  upm,
  input  logic                  adi,
  input  logic                  aeoi,
  input  logic [2:0]            icw1_hi,
  input  logic [7:0]            icw2,
`ifdef POLL_CMD_EN
  input  logic                  poll,
`endif
  input  logic                  int_valid,
  input  logic [2:0]            int_level,
  output logic                  freeze,
  output logic                  isr_set,
  output logic                  eoi_clr,
  output logic [2:0]            ack_level
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ACT, S_ACK1, S_WAIT2, S_ACK2, S_WAIT3, S_ACK3
  } state_t;

  state_t     r_state, w_state_n;
  logic       r_rd_prev, r_inta_prev;
  logic [7:0] r_d_out, w_d_out_n;
  logic       r_d_oe, w_d_oe_n;
  logic       r_freeze, w_freeze_n;
  logic       r_isr_set, w_isr_set_n;
  logic       r_eoi_clr, w_eoi_clr_n;
  logic [2:0] r_ack_level, w_ack_level_n;
  logic       r_spurious, w_spurious_n;
  logic       r_poll_hold, w_poll_hold_n;

  logic w_rd_fall, w_rd_rise, w_inta_fall, w_inta_rise;

  assign w_rd_fall   =  r_rd_prev   & ~bus.rd;
  assign w_rd_rise   = ~r_rd_prev   &  bus.rd;
  assign w_inta_fall =  r_inta_prev & ~bus.inta;
  assign w_inta_rise = ~r_inta_prev &  bus.inta;

  function automatic logic [7:0] rd_byte(input logic a0, input logic sel_isr,
                                         input logic [7:0] v_irr, input logic [7:0] v_isr,
                                         input logic [7:0] v_imr);
    if (a0)           rd_byte = v_imr;
    else if (sel_isr) rd_byte = v_isr;
    else              rd_byte = v_irr;
  endfunction

  // Second INTA byte: 8086 vector, or the low call-address byte for 8080/85.
  function automatic logic [7:0] ack2_byte(input logic m86, input logic a4,
                                           input logic [2:0] hi, input logic [7:0] base,
                                           input logic [2:0] lvl);
    if (m86)     ack2_byte = {base[7:3], lvl};
    else if (a4) ack2_byte = {hi[2:0], lvl, 2'b00};
    else         ack2_byte = {hi[2:1], lvl, 3'b000};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_prev   <= 1'b1;
      r_inta_prev <= 1'b1;
      r_d_out     <= 8'h00;
      r_d_oe      <= 1'b0;
      r_freeze    <= 1'b0;
      r_isr_set   <= 1'b0;
      r_eoi_clr   <= 1'b0;
      r_ack_level <= 3'd0;
      r_spurious  <= 1'b0;
      r_poll_hold <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_rd_prev   <= bus.rd;
      r_inta_prev <= bus.inta;
      r_d_out     <= w_d_out_n;
      r_d_oe      <= w_d_oe_n;
      r_freeze    <= w_freeze_n;
      r_isr_set   <= w_isr_set_n;
      r_eoi_clr   <= w_eoi_clr_n;
      r_ack_level <= w_ack_level_n;
      r_spurious  <= w_spurious_n;
      r_poll_hold <= w_poll_hold_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_d_out_n     = r_d_out;
    w_d_oe_n      = r_d_oe;
    w_freeze_n    = 1'b0;
    w_isr_set_n   = 1'b0;
    w_eoi_clr_n   = 1'b0;
    w_ack_level_n = r_ack_level;
    w_spurious_n  = r_spurious;
    w_poll_hold_n = r_poll_hold;
    case (r_state)
      S_IDLE: begin
        w_d_oe_n = 1'b0;
        if (w_inta_fall) begin
          w_ack_level_n = int_valid ? int_level : SPURIOUS_LEVEL;
          w_freeze_n    = 1'b1;
          w_isr_set_n   = int_valid;
          w_spurious_n  = ~int_valid;
          w_state_n     = S_ACK1;
          if (!upm) begin
            w_d_out_n = CALL_OPCODE;
            w_d_oe_n  = 1'b1;
          end
        end else if (w_rd_fall && !bus.CS) begin
          w_state_n     = S_RD_ACT;
          w_d_oe_n      = 1'b1;
          w_d_out_n     = rd_byte(bus.A0, ris, irr, isr, imr);
          w_poll_hold_n = 1'b0;
`ifdef POLL_CMD_EN
          // A poll read freezes its byte for the whole read cycle.
          if (!bus.A0 && poll) begin
            w_d_out_n     = {int_valid, 4'b0000, int_level};
            w_poll_hold_n = 1'b1;
            if (int_valid) begin
              w_freeze_n    = 1'b1;
              w_isr_set_n   = 1'b1;
              w_ack_level_n = int_level;
            end
          end
`endif
        end
      end
      S_RD_ACT: begin
        if (w_rd_rise || bus.CS) begin
          w_d_oe_n  = 1'b0;
          w_state_n = S_IDLE;
        end else if (!r_poll_hold) begin
          w_d_out_n = rd_byte(bus.A0, ris, irr, isr, imr);
        end
      end
      S_ACK1: begin
        if (w_inta_rise) begin
          w_d_oe_n  = 1'b0;
          w_state_n = S_WAIT2;
        end else if (upm) begin
          w_d_oe_n  = 1'b0;
        end else begin
          w_d_out_n = CALL_OPCODE;
          w_d_oe_n  = 1'b1;
        end
      end
      S_WAIT2: begin
        w_d_oe_n = 1'b0;
        if (w_inta_fall) begin
          w_state_n = S_ACK2;
          w_d_oe_n  = 1'b1;
          w_d_out_n = ack2_byte(upm, adi, icw1_hi, icw2, r_ack_level);
        end
      end
      S_ACK2: begin
        if (w_inta_rise) begin
          w_d_oe_n = 1'b0;
          if (upm) begin
            w_eoi_clr_n = aeoi & ~r_spurious;
            w_state_n   = S_IDLE;
          end else begin
            w_state_n   = S_WAIT3;
          end
        end else begin
          w_d_out_n = ack2_byte(upm, adi, icw1_hi, icw2, r_ack_level);
        end
      end
      S_WAIT3: begin
        w_d_oe_n = 1'b0;
        if (w_inta_fall) begin
          w_state_n = S_ACK3;
          w_d_oe_n  = 1'b1;
          w_d_out_n = icw2;
        end
      end
      S_ACK3: begin
        if (w_inta_rise) begin
          w_d_oe_n    = 1'b0;
          w_eoi_clr_n = aeoi & ~r_spurious;
          w_state_n   = S_IDLE;
        end else begin
          w_d_out_n = icw2;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_d_oe_n  = 1'b0;
      end
    endcase
  end

  assign bus.d_out = r_d_out;
  assign bus.d_oe  = r_d_oe;
  assign freeze    = r_freeze;
  assign isr_set   = r_isr_set;
  assign eoi_clr   = r_eoi_clr;
  assign ack_level = r_ack_level;

endmodule

// File: tb/tb_pic_bus_responder.sv
// Scoreboard bench for pic_bus_responder: expected bus bytes are queued as strobes are driven.
module tb_pic_bus_responder;
  logic       clk, rst_n;
  logic [7:0] irr, isr, imr, icw2;
  logic       ris, upm, adi, aeoi, int_valid;
  logic [2:0] icw1_hi, int_level, ack_level;
  logic       freeze, isr_set, eoi_clr;
`ifdef POLL_CMD_EN
  logic       poll;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_v;

  pic_bus_responder_if bus_if();

  pic_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave),
    .irr(irr), .isr(isr), .imr(imr), .ris(ris), .upm(upm), .adi(adi), .aeoi(aeoi),
    .icw1_hi(icw1_hi), .icw2(icw2),
`ifdef POLL_CMD_EN
    .poll(poll),
`endif
    .int_valid(int_valid), .int_level(int_level),
    .freeze(freeze), .isr_set(isr_set), .eoi_clr(eoi_clr), .ack_level(ack_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_if.rd = 1'b1; bus_if.inta = 1'b1; bus_if.CS = 1'b1; bus_if.A0 = 1'b0;
    irr = 8'h00; isr = 8'h00; imr = 8'h00; ris = 0; upm = 1; adi = 1; aeoi = 0;
    icw1_hi = 3'd0; icw2 = 8'h00; int_valid = 0; int_level = 3'd0;
`ifdef POLL_CMD_EN
    poll = 1'b0;
`endif
    #2;
    checks++;
    if ({bus_if.d_oe, bus_if.d_out, freeze, isr_set, eoi_clr, ack_level} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got oe=%b d=%h fr=%b set=%b eoi=%b lvl=%0d required all 0",
               bus_if.d_oe, bus_if.d_out, freeze, isr_set, eoi_clr, ack_level);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_8086();
    upm = 1; icw2 = 8'h40; int_valid = 1; int_level = 3'd5; aeoi = 1;
    bus_if.inta = 1'b0;
    tick();
    checks++;
    if ({freeze, isr_set, ack_level, bus_if.d_oe} !== {1'b1, 1'b1, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL i86_pulse1 got fr=%b set=%b lvl=%0d oe=%b required 1 1 5 0",
               freeze, isr_set, ack_level, bus_if.d_oe);
    end
    int_level = 3'd2; int_valid = 0;
    tick();
    checks++;
    if ({freeze, isr_set, bus_if.d_oe} !== 3'b000) begin
      errors++;
      $display("FAIL i86_pulse_width got fr=%b set=%b oe=%b required 0 0 0", freeze, isr_set, bus_if.d_oe);
    end
    bus_if.inta = 1'b1;
    tick();
    bus_if.inta = 1'b0;
    sb.push_back({1'b1, 8'h45});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
      errors++;
      $display("FAIL i86_vector got %b/%h required %b/%h", bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
    end
    bus_if.inta = 1'b1;
    tick();
    checks++;
    if ({eoi_clr, bus_if.d_oe} !== 2'b10) begin
      errors++;
      $display("FAIL i86_eoi got eoi=%b oe=%b required 1 0", eoi_clr, bus_if.d_oe);
    end
    tick();
    checks++;
    if (eoi_clr !== 1'b0) begin
      errors++;
      $display("FAIL i86_eoi_width got %b required 0", eoi_clr);
    end
  endtask

  task automatic test_8080();
    logic [7:0] bytes [2][3];
    logic [2:0] his [2];
    logic [2:0] lvls [2];
    logic       adis [2];
    bytes[0][0] = 8'hCD; bytes[0][1] = 8'hAC; bytes[0][2] = 8'h12;
    bytes[1][0] = 8'hCD; bytes[1][1] = 8'hB0; bytes[1][2] = 8'h34;
    his[0] = 3'b101; his[1] = 3'b100; lvls[0] = 3'd3; lvls[1] = 3'd6; adis[0] = 1; adis[1] = 0;
    for (int c = 0; c < 2; c++) begin
      upm = 0; adi = adis[c]; icw1_hi = his[c]; icw2 = bytes[c][2];
      int_valid = 1; int_level = lvls[c]; aeoi = (c == 1);
      for (int p = 0; p < 3; p++) begin
        bus_if.inta = 1'b0;
        sb.push_back({1'b1, bytes[c][p]});
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
          errors++;
          $display("FAIL i80_byte cfg=%0d pulse=%0d got %b/%h required %b/%h",
                   c, p, bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
        end
        bus_if.inta = 1'b1;
        tick();
        checks++;
        if ({bus_if.d_oe, eoi_clr} !== {1'b0, (p == 2) && (c == 1)}) begin
          errors++;
          $display("FAIL i80_release cfg=%0d pulse=%0d got oe=%b eoi=%b required 0 %b",
                   c, p, bus_if.d_oe, eoi_clr, (p == 2) && (c == 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_spurious();
    upm = 1; icw2 = 8'h08; aeoi = 1; int_valid = 0; int_level = 3'd2;
    bus_if.inta = 1'b0;
    tick();
    checks++;
    if ({freeze, isr_set, ack_level} !== {1'b1, 1'b0, 3'd7}) begin
      errors++;
      $display("FAIL spur_pulse1 got fr=%b set=%b lvl=%0d required 1 0 7", freeze, isr_set, ack_level);
    end
    bus_if.inta = 1'b1;
    tick();
    bus_if.inta = 1'b0;
    sb.push_back({1'b1, 8'h0F});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
      errors++;
      $display("FAIL spur_vector got %b/%h required %b/%h", bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
    end
    bus_if.inta = 1'b1;
    tick();
    checks++;
    if ({eoi_clr, isr_set} !== 2'b00) begin
      errors++;
      $display("FAIL spur_no_eoi got eoi=%b set=%b required 0 0", eoi_clr, isr_set);
    end
    tick();
  endtask

  task automatic test_status();
    logic [1:0] sel [3];
    logic [7:0] want [3];
    irr = 8'hA5; isr = 8'h3C; imr = 8'hF0;
    sel[0] = 2'b00; want[0] = 8'hA5;
    sel[1] = 2'b01; want[1] = 8'h3C;
    sel[2] = 2'b10; want[2] = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      bus_if.A0 = sel[i][1]; ris = sel[i][0]; bus_if.CS = 1'b0; bus_if.rd = 1'b0;
      sb.push_back({1'b1, want[i]});
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
        errors++;
        $display("FAIL status_read sel=%b got %b/%h required %b/%h",
                 sel[i], bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
      end
      if (i == 0) begin
        irr = 8'h5A;
        sb.push_back({1'b1, 8'h5A});
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
          errors++;
          $display("FAIL status_live got %b/%h required %b/%h", bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
        end
        irr = 8'hA5;
      end
      bus_if.rd = 1'b1;
      tick();
      checks++;
      if (bus_if.d_oe !== 1'b0) begin
        errors++;
        $display("FAIL status_release sel=%b got oe=%b required 0", sel[i], bus_if.d_oe);
      end
      bus_if.CS = 1'b1;
      tick();
    end
    bus_if.A0 = 1'b0; bus_if.CS = 1'b1; bus_if.rd = 1'b0;
    tick(); tick();
    checks++;
    if (bus_if.d_oe !== 1'b0) begin
      errors++;
      $display("FAIL status_cs_high got oe=%b required 0", bus_if.d_oe);
    end
    bus_if.rd = 1'b1;
    tick();
  endtask

  task automatic test_collision();
    logic [7:0] seq [3];
    seq[0] = 8'hCD; seq[1] = 8'hAC; seq[2] = 8'h12;
    upm = 0; adi = 1; icw1_hi = 3'b101; icw2 = 8'h12; int_valid = 1; int_level = 3'd3; aeoi = 0;
    irr = 8'hA5; ris = 0; bus_if.A0 = 1'b0; bus_if.CS = 1'b0;
    bus_if.rd = 1'b0; bus_if.inta = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bus_if.inta = 1'b0;
      sb.push_back({1'b1, seq[p]});
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
        errors++;
        $display("FAIL collide_byte pulse=%0d got %b/%h required %b/%h",
                 p, bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
      end
      bus_if.inta = 1'b1;
      tick();
    end
    tick();
    checks++;
    if (bus_if.d_oe !== 1'b0) begin
      errors++;
      $display("FAIL collide_rd_dropped got oe=%b d=%h required oe 0", bus_if.d_oe, bus_if.d_out);
    end
    bus_if.rd = 1'b1; bus_if.CS = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    upm = 1; icw2 = 8'h40; int_valid = 1; int_level = 3'd1; aeoi = 1;
    bus_if.inta = 1'b0; tick();
    bus_if.inta = 1'b1; tick();
    bus_if.inta = 1'b0;
    sb.push_back({1'b1, 8'h41});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
      errors++;
      $display("FAIL rstmid_drive got %b/%h required %b/%h", bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.d_oe, eoi_clr} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_async got oe=%b eoi=%b required 0 0", bus_if.d_oe, eoi_clr);
    end
    bus_if.inta = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus_if.d_oe, eoi_clr} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_after got oe=%b eoi=%b required 0 0", bus_if.d_oe, eoi_clr);
    end
    imr = 8'hF0; bus_if.A0 = 1'b1; bus_if.CS = 1'b0; bus_if.rd = 1'b0;
    sb.push_back({1'b1, 8'hF0});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({bus_if.d_oe, bus_if.d_out} !== exp_v) begin
      errors++;
      $display("FAIL rstmid_idle_read got %b/%h required %b/%h", bus_if.d_oe, bus_if.d_out, exp_v[8], exp_v[7:0]);
    end
    bus_if.rd = 1'b1; bus_if.CS = 1'b1; bus_if.A0 = 1'b0;
    tick(); tick();
  endtask

`ifdef POLL_CMD_EN
  task automatic test_poll();
    poll = 1'b1; int_valid = 1; int_level = 3'd4;
    bus_if.A0 = 1'b0; bus_if.CS = 1'b0; bus_if.rd = 1'b0;
    sb.push_back({1'b1, 8'h84});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({bus_if.d_oe, bus_if.d_out, freeze, isr_set, ack_level} !== {exp_v, 1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL poll_read got %b/%h fr=%b set=%b lvl=%0d required %b/%h 1 1 4",
               bus_if.d_oe, bus_if.d_out, freeze, isr_set, ack_level, exp_v[8], exp_v[7:0]);
    end
    bus_if.rd = 1'b1; bus_if.CS = 1'b1; poll = 1'b0;
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_8086();
    test_8080();
    test_spurious();
    test_status();
    test_collision();
    test_reset_mid();
`ifdef POLL_CMD_EN
    test_poll();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
